// File: rtl/serial_add_ctrl_if.sv
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Requester-side handshake and operand bus for serial_add_ctrl.
//               The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             Cout;

  modport master (
    output start, a, b, Cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, s, Cout
  );

  modport slave (
    input  start, a, b, Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, s, Cout
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder sequencing one fulladder LSB-first over WIDTH
//               bits. Optional subtract mode enabled by SERIAL_ADD_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
  input  wire logic a,
  input  wire logic b,
  input  wire logic Cin,
  output logic      s,
  output logic      Cout
);
  assign s    = a ^ b ^ Cin;
  assign Cout = (a & b) | (a & Cin) | (b & Cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               w_busy;
  logic               w_done;
  logic               w_b_bit;
  logic               w_cin_init;
  logic               w_sum;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;
  // Subtraction is A + ~B + 1: invert B per bit and seed the carry with 1.
  assign w_b_bit    = r_b[0] ^ r_sub;
  assign w_cin_init = bus.sub ? 1'b1 : bus.Cin;
`else
  assign w_b_bit    = r_b[0];
  assign w_cin_init = bus.Cin;
`endif

  fulladder u_fa (
    .a    (r_a[0]),
    .b    (w_b_bit),
    .Cin  (r_carry),
    .s    (w_sum),
    .Cout (w_cout)
  );

  assign w_last     = (r_cnt == c_LAST);
  assign w_res_next = (WIDTH'(w_sum) << (WIDTH - 1)) | (r_res >> 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: if (bus.start) w_state_next = c_S_RUN;
      c_S_RUN:  if (w_last)    w_state_next = c_S_DONE;
      c_S_DONE:                w_state_next = c_S_IDLE;
      default:                 w_state_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_S_RUN:  w_busy = 1'b1;
      c_S_DONE: w_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= w_cin_init;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= bus.sub;
`endif
          end
        end
        c_S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + c_CNT_W'(1);
          // Outputs update only on the edge that completes the operation.
          if (w_last) begin
            r_s    <= w_res_next;
            r_cout <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.s    = r_s;
  assign bus.Cout = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 8): vector table, random
// operations against an arithmetic model, held-start churn and abort sequences.
`default_nettype none

module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] last_s = '0;
  logic         last_c = 1'b0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain W+1-bit arithmetic; subtract as A + (2^W-1-B) + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic set_inputs(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.Cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`endif
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] es, input logic ec);
    set_inputs(a, b, cin, sub);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    set_inputs(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < W; i++) begin
      chk({nm, "_busy"}, {bus.busy, bus.done}, 2'b10);
      chk({nm, "_s_hold"}, {bus.Cout, bus.s}, {last_c, last_s});
      @(negedge clk);
    end
    chk({nm, "_done"}, {bus.busy, bus.done}, 2'b01);
    chk({nm, "_s"}, bus.s, es);
    chk({nm, "_cout"}, bus.Cout, ec);
    last_s = es;
    last_c = ec;
    @(negedge clk);
    chk({nm, "_idle"}, {bus.busy, bus.done}, 2'b00);
  endtask

  vec_t vt[$];

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ta, tb;
    logic         tc, ts;
    logic [W:0]   held_exp;

    vt.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
    vt.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
    vt.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vt.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vt.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vt.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0});
    vt.push_back('{8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1});
    vt.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
`endif

    // Reset held with start asserted
    rst = 1'b1;
    bus.start = 1'b1;
    set_inputs(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ctrl", {bus.busy, bus.done}, 2'b00);
      chk("rst_s", {bus.Cout, bus.s}, 9'h000);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_start", {bus.busy, bus.done}, 2'b00);
    end

    // Vector table
    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].s, vt[i].cout);

    // Random operations against the model
    for (int n = 0; n < 12; n++) begin
      ta = W'($urandom);
      tb = W'($urandom);
      tc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      r = model(ta, tb, tc, ts);
      do_op("rand", ta, tb, tc, ts, r[W-1:0], r[W]);
    end

    // Held start with churning operands: accepts at edges 0,10,20,...
    ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
    set_inputs(ta, tb, tc, 1'b0);
    held_exp = model(ta, tb, tc, 1'b0);
    bus.start = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      @(negedge clk);
      chk("held_done", bus.done, ((c % (W + 2)) == W) ? 1 : 0);
      if ((c % (W + 2)) == W) begin
        chk("held_s", {bus.Cout, bus.s}, held_exp);
        last_s = held_exp[W-1:0];
        last_c = held_exp[W];
      end else begin
        chk("held_s_stable", {bus.Cout, bus.s}, {last_c, last_s});
      end
      ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
      set_inputs(ta, tb, tc, 1'b0);
      if (((c + 1) % (W + 2)) == 0) held_exp = model(ta, tb, tc, 1'b0);
      if (c == 48) bus.start = 1'b0;
    end
    @(negedge clk);
    chk("held_end_idle", {bus.busy, bus.done}, 2'b00);

    // Abort on the 4th RUN edge
    set_inputs(8'h0F, 8'h01, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctrl", {bus.busy, bus.done}, 2'b00);
    chk("abort_s", {bus.Cout, bus.s}, 9'h000);
    rst = 1'b0;
    last_s = '0;
    last_c = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_done", {bus.busy, bus.done, bus.Cout, bus.s}, 11'h000);
    end
    do_op("post_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
